audio_io_ctrl: RTL and testbench

AUDIO_IO_CTRL -- requirements
Module: audio_io_ctrl

---
 rtl/audio_io_pkg.sv | 14 +
 rtl/audio_io_ctrl_sync_fifo.sv | 55 +++++
 rtl/audio_io_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_audio_io_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/audio_io_pkg.sv
// Shared types and default sizing for the audio I/O controller.
package audio_io_pkg;

  localparam int unsigned DEF_DWIDTH  = 32;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_TICKDIV = 1042;

  // DAC output handshake state.
  typedef enum logic {
    OUT_WAIT = 1'b0,
    OUT_SEND = 1'b1
  } out_state_t;

endpackage

// File: rtl/audio_io_ctrl_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// dout_o whenever the FIFO is non-empty, and dout_o reads 0 when it is empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] din_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full and empty conditions.
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Advance the pointers; they wrap naturally modulo 2*DEPTH.
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/audio_io_ctrl.sv
// Audio I/O controller: buffers ADC samples for the CPU, buffers CPU output
// samples for the DAC, paces the DAC with a sample-rate tick and records
// sticky overrun / underrun / late flags.
module audio_io_ctrl
  import audio_io_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TICKDIV = DEF_TICKDIV
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              adc_valid,
  input  logic [DWIDTH-1:0] adc_data,
  output logic              adc_ready,
  input  logic              cpu_input_ready,
  output logic [DWIDTH-1:0] cpu_adcdata,
  input  logic              cpu_output_valid,
  input  logic [DWIDTH-1:0] cpu_outport,
  output logic              cpu_stall,
  output logic              dac_valid,
  output logic [DWIDTH-1:0] dac_data,
  input  logic              dac_ready,
  input  logic              clr_flags,
  output logic              overrun,
  output logic              underrun,
  output logic              late
);

  localparam int CW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TICKDIV - 1);

  // FIFO handshakes
  logic              in_full, in_empty;
  logic              out_full, out_empty;
  logic [DWIDTH-1:0] out_head;
  logic              in_push, in_pop;
  logic              out_push, fsm_pop;

  // Tick counter
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tick;

  // DAC FSM
  out_state_t        state_q, state_d;
  logic              dac_valid_q, dac_valid_d;
  logic [DWIDTH-1:0] dac_data_q, dac_data_d;
  logic              underrun_set, late_set, overrun_set;

  // Sticky flags
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic              late_q, late_d;

  // ---------------------------------------------------------------------
  // CPU / ADC handshakes. A pop by the DAC FSM frees a slot in the same
  // cycle, so a full output FIFO does not stall the CPU on a draining tick.
  // Both handshakes are forced quiet while reset is asserted.
  // ---------------------------------------------------------------------
  assign adc_ready   = !reset && !in_full;
  assign cpu_stall   = !reset &&
                       ((cpu_input_ready && in_empty) ||
                        (cpu_output_valid && out_full && !fsm_pop));
  assign in_push     = adc_valid && adc_ready;
  assign in_pop      = cpu_input_ready && !cpu_stall;
  assign out_push    = cpu_output_valid && !cpu_stall;
  assign overrun_set = adc_valid && in_full;

  sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (in_push),
    .din_i   (adc_data),
    .pop_i   (in_pop),
    .dout_o  (cpu_adcdata),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (out_push),
    .din_i   (cpu_outport),
    .pop_i   (fsm_pop),
    .dout_o  (out_head),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  // ---------------------------------------------------------------------
  // Sample-rate tick: one cycle in every TICKDIV.
  // ---------------------------------------------------------------------
  assign tick = (cnt_q == TMAX);

  // Next count, wrapping at TICKDIV-1.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Tick counter register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------
  // DAC FSM
  // ---------------------------------------------------------------------
  // State and DAC output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= OUT_WAIT;
      dac_valid_q <= 1'b0;
      dac_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      dac_valid_q <= dac_valid_d;
      dac_data_q  <= dac_data_d;
    end
  end

  // Next state: leave WAIT on a tick, leave SEND on DAC acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_WAIT: if (tick)      state_d = OUT_SEND;
      OUT_SEND: if (dac_ready) state_d = OUT_WAIT;
      default:                 state_d = OUT_WAIT;
    endcase
  end

  // Outputs: load a sample (or silence) on a tick; hold it until accepted.
  // A tick while a sample is still pending is dropped.
  always_comb begin
    dac_valid_d  = dac_valid_q;
    dac_data_d   = dac_data_q;
    fsm_pop      = 1'b0;
    underrun_set = 1'b0;
    late_set     = 1'b0;
    case (state_q)
      OUT_WAIT: begin
        if (tick) begin
          dac_valid_d  = 1'b1;
          dac_data_d   = out_empty ? '0 : out_head;
          fsm_pop      = !out_empty;
          underrun_set = out_empty;
        end
      end
      OUT_SEND: begin
        if (dac_ready) dac_valid_d = 1'b0;
        late_set = tick && !dac_ready;
      end
      default: ;
    endcase
  end

  assign dac_valid = dac_valid_q;
  assign dac_data  = dac_data_q;

  // ---------------------------------------------------------------------
  // Sticky flags: a set event beats a clear in the same cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    overrun_d  = overrun_set  ? 1'b1 : (clr_flags ? 1'b0 : overrun_q);
    underrun_d = underrun_set ? 1'b1 : (clr_flags ? 1'b0 : underrun_q);
    late_d     = late_set     ? 1'b1 : (clr_flags ? 1'b0 : late_q);
  end

  // Flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      late_q     <= late_d;
    end
  end

  assign overrun  = overrun_q;
  assign underrun = underrun_q;
  assign late     = late_q;

endmodule

// File: tb/tb_audio_io_ctrl.sv
// Randomized bench for audio_io_ctrl against a queue-based reference model.
// Inputs change on the falling edge; outputs are checked shortly after.
module tb_audio_io_ctrl;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int TD = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_ready;
  logic          cpu_input_ready = 1'b0;
  logic [DW-1:0] cpu_adcdata;
  logic          cpu_output_valid = 1'b0;
  logic [DW-1:0] cpu_outport = '0;
  logic          cpu_stall;
  logic          dac_valid;
  logic [DW-1:0] dac_data;
  logic          dac_ready = 1'b0;
  logic          clr_flags = 1'b0;
  logic          overrun, underrun, late;

  always #5 clock = ~clock;

  audio_io_ctrl #(.DWIDTH(DW), .DEPTH(DP), .TICKDIV(TD)) dut (
    .clock            (clock),
    .reset            (reset),
    .adc_valid        (adc_valid),
    .adc_data         (adc_data),
    .adc_ready        (adc_ready),
    .cpu_input_ready  (cpu_input_ready),
    .cpu_adcdata      (cpu_adcdata),
    .cpu_output_valid (cpu_output_valid),
    .cpu_outport      (cpu_outport),
    .cpu_stall        (cpu_stall),
    .dac_valid        (dac_valid),
    .dac_data         (dac_data),
    .dac_ready        (dac_ready),
    .clr_flags        (clr_flags),
    .overrun          (overrun),
    .underrun         (underrun),
    .late             (late)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [DW-1:0] inq[$];
  logic [DW-1:0] outq[$];
  int            cyc;      // cycles since reset; tick when cyc % TD == TD-1
  bit            pend;     // a DAC sample is being presented
  logic [DW-1:0] dval;
  bit            m_ov, m_un, m_lt;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    inq.delete();
    outq.delete();
    cyc  = 0;
    pend = 0;
    dval = '0;
    m_ov = 0;
    m_un = 0;
    m_lt = 0;
  endtask

  function automatic bit m_tick();
    return (cyc % TD) == TD - 1;
  endfunction

  function automatic bit m_stall();
    bit dac_takes;
    if (reset) return 0;
    // On a tick with nothing pending, the DAC side takes a sample this cycle.
    dac_takes = m_tick() && !pend && outq.size() > 0;
    return (cpu_input_ready && inq.size() == 0) ||
           (cpu_output_valid && outq.size() == DP && !dac_takes);
  endfunction

  task automatic check_outputs();
    logic [DW-1:0] head;
    bit            rdy;
    head = '0;
    if (inq.size() > 0) head = inq[0];
    rdy = !reset && inq.size() < DP;
    chk("adc_ready",   adc_ready,   rdy);
    chk("cpu_stall",   cpu_stall,   m_stall());
    chk("cpu_adcdata", cpu_adcdata, head);
    chk("dac_valid",   dac_valid,   pend);
    chk("dac_data",    dac_data,    dval);
    chk("overrun",     overrun,     m_ov);
    chk("underrun",    underrun,    m_un);
    chk("late",        late,        m_lt);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    bit st, tk, ov_s, un_s, lt_s;
    if (reset) begin
      model_clear();
      return;
    end
    st = m_stall();
    tk = m_tick();
    ov_s = 0; un_s = 0; lt_s = 0;
    // ADC side
    if (adc_valid) begin
      if (inq.size() < DP) inq.push_back(adc_data);
      else ov_s = 1;
    end
    // CPU read happens before the ADC push lands only logically; a pop
    // requires the queue to have been non-empty at the start of the cycle.
    if (cpu_input_ready && !st) void'(inq.pop_front());
    // DAC side drains first so a full queue can still accept the CPU write.
    if (!pend) begin
      if (tk) begin
        pend = 1;
        if (outq.size() > 0) dval = outq.pop_front();
        else begin dval = '0; un_s = 1; end
      end
    end else begin
      if (tk && !dac_ready) lt_s = 1;
      if (dac_ready) pend = 0;
    end
    if (cpu_output_valid && !st) outq.push_back(cpu_outport);
    m_ov = ov_s ? 1'b1 : (clr_flags ? 1'b0 : m_ov);
    m_un = un_s ? 1'b1 : (clr_flags ? 1'b0 : m_un);
    m_lt = lt_s ? 1'b1 : (clr_flags ? 1'b0 : m_lt);
    cyc++;
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Phase bias table: adc_valid, cpu_input_ready, cpu_output_valid,
  // dac_ready, reset, clr_flags (percent).
  int prob [6][6] = '{
    '{70,  0,  0, 100, 0,  0},   // fill input FIFO, overrun
    '{40, 50, 30, 100, 0,  5},   // mixed traffic
    '{10, 40, 85,  10, 0,  5},   // output FIFO full, late DAC
    '{ 0, 70,  0,  90, 0,  0},   // input underflow stalls, DAC underrun
    '{50, 50, 50,  50, 4, 10},   // random resets mid-transfer
    '{30, 30, 70,  60, 0, 20}    // flag clears versus sets
  };

  initial begin
    // Hold reset across two edges; the model starts in the reset state.
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_outputs();
    model_step();

    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 160; c++) begin
        @(negedge clock);
        reset            = roll(prob[p][4]);
        adc_valid        = roll(prob[p][0]);
        adc_data         = $urandom;
        cpu_input_ready  = roll(prob[p][1]);
        cpu_output_valid = roll(prob[p][2]);
        cpu_outport      = $urandom;
        dac_ready        = roll(prob[p][3]);
        clr_flags        = roll(prob[p][5]);
        #1;
        check_outputs();
        model_step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
